// File: rtl/controle_direcao_if.sv
// Bus between the elevator direction controller and its datapath: floor
// requests in; floor, motor direction, door and pending-request state out.
interface controle_direcao_if #(
   parameter int N_ANDARES = 8,
   parameter int W         = 3
);
   logic [N_ANDARES-1:0] botao;
   logic [W-1:0]         andar;
   logic                 sobe;
   logic                 desce;
   logic                 porta_aberta;
   logic [N_ANDARES-1:0] pendentes;
   logic                 ocupado;
   logic [1:0]           estado;

   // botao is a plain level input sampled on every rising edge; there is no
   // valid/ready pairing: a request bit is accepted by the edge that sees it.
   modport master (
      output botao,
      input  andar, sobe, desce, porta_aberta, pendentes, ocupado, estado
   );

   modport slave (
      input  botao,
      output andar, sobe, desce, porta_aberta, pendentes, ocupado, estado
   );
endinterface

// File: rtl/controle_direcao.sv
// SCAN elevator controller: latches floor requests, tracks the car floor and
// keeps moving one way while requests lie ahead, stopping at requested floors.
module controle_direcao #(
   parameter int N_ANDARES = 8,
   parameter int W         = 3,
   parameter int T_VIAGEM  = 2,
   parameter int T_PORTA   = 4
) (
   input logic               clk,
   input logic               rst_n,
   controle_direcao_if.slave bus
);

   localparam int CWV = (T_VIAGEM > 1) ? $clog2(T_VIAGEM) : 1;
   localparam int CWP = (T_PORTA > 1) ? $clog2(T_PORTA) : 1;
   localparam logic [CWV-1:0] VIAGEM_FIM = CWV'(T_VIAGEM - 1);
   localparam logic [CWP-1:0] PORTA_FIM  = CWP'(T_PORTA - 1);

   typedef enum logic [1:0] {
      PARADO   = 2'd0,
      SUBINDO  = 2'd1,
      DESCENDO = 2'd2,
      PORTA    = 2'd3
   } estado_t;

   estado_t              estado, estado_nxt;
   logic [W-1:0]         andar_q, andar_nxt;
   logic [N_ANDARES-1:0] pend, pend_nxt;
   logic                 dir_ult, dir_nxt;
   logic [CWV-1:0]       cnt_v, cnt_v_nxt;
   logic [CWP-1:0]       cnt_p, cnt_p_nxt;
   logic [W-1:0]         prox;
   logic [N_ANDARES-1:0] limpa;
   logic [N_ANDARES-1:0] botao_ef;
   logic                 ha_frente;
   logic                 ha_tras;

   function automatic logic ha_acima(input logic [N_ANDARES-1:0] p,
                                     input logic [W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < N_ANDARES; i++)
         if (p[i] && (i > int'(f))) r = 1'b1;
      return r;
   endfunction

   function automatic logic ha_abaixo(input logic [N_ANDARES-1:0] p,
                                      input logic [W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < N_ANDARES; i++)
         if (p[i] && (i < int'(f))) r = 1'b1;
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado  <= PARADO;
         andar_q <= '0;
         pend    <= '0;
         dir_ult <= 1'b1;
         cnt_v   <= '0;
         cnt_p   <= '0;
      end else begin
         estado  <= estado_nxt;
         andar_q <= andar_nxt;
         pend    <= pend_nxt;
         dir_ult <= dir_nxt;
         cnt_v   <= cnt_v_nxt;
         cnt_p   <= cnt_p_nxt;
      end
   end

   always_comb begin
      estado_nxt = estado;
      andar_nxt  = andar_q;
      dir_nxt    = dir_ult;
      cnt_v_nxt  = cnt_v;
      cnt_p_nxt  = cnt_p;
      prox       = andar_q;
      limpa      = '0;
      botao_ef   = bus.botao;
      ha_frente  = 1'b0;
      ha_tras    = 1'b0;

      case (estado)
         PARADO: begin
            if (pend[andar_q]) begin
               estado_nxt     = PORTA;
               cnt_p_nxt      = '0;
               limpa[andar_q] = 1'b1;
            end else if (ha_acima(pend, andar_q)) begin
               estado_nxt = SUBINDO;
               dir_nxt    = 1'b1;
               cnt_v_nxt  = '0;
            end else if (ha_abaixo(pend, andar_q)) begin
               estado_nxt = DESCENDO;
               dir_nxt    = 1'b0;
               cnt_v_nxt  = '0;
            end
         end

         SUBINDO, DESCENDO: begin
            if (cnt_v == VIAGEM_FIM) begin
               // Next decision is made from the floor being arrived at.
               prox      = (estado == SUBINDO) ? andar_q + W'(1) : andar_q - W'(1);
               andar_nxt = prox;
               cnt_v_nxt = '0;
               ha_frente = (estado == SUBINDO) ? ha_acima(pend, prox) : ha_abaixo(pend, prox);
               ha_tras   = (estado == SUBINDO) ? ha_abaixo(pend, prox) : ha_acima(pend, prox);
               if (pend[prox]) begin
                  estado_nxt  = PORTA;
                  cnt_p_nxt   = '0;
                  limpa[prox] = 1'b1;
               end else if (!ha_frente) begin
                  if (ha_tras) begin
                     estado_nxt = (estado == SUBINDO) ? DESCENDO : SUBINDO;
                     dir_nxt    = (estado == DESCENDO);
                  end else begin
                     estado_nxt = PARADO;
                  end
               end
            end else begin
               cnt_v_nxt = cnt_v + CWV'(1);
            end
         end

         PORTA: begin
            // A press at the open floor reopens the door instead of queueing.
            botao_ef[andar_q] = 1'b0;
            ha_frente = dir_ult ? ha_acima(pend, andar_q) : ha_abaixo(pend, andar_q);
            ha_tras   = dir_ult ? ha_abaixo(pend, andar_q) : ha_acima(pend, andar_q);
            if (bus.botao[andar_q]) begin
               cnt_p_nxt = '0;
            end else if (cnt_p == PORTA_FIM) begin
               cnt_p_nxt = '0;
               cnt_v_nxt = '0;
               if (ha_frente) begin
                  estado_nxt = dir_ult ? SUBINDO : DESCENDO;
               end else if (ha_tras) begin
                  estado_nxt = dir_ult ? DESCENDO : SUBINDO;
                  dir_nxt    = ~dir_ult;
               end else begin
                  estado_nxt = PARADO;
               end
            end else begin
               cnt_p_nxt = cnt_p + CWP'(1);
            end
         end

         default: estado_nxt = PARADO;
      endcase

      // New requests win over the bit being served, except the door floor.
      pend_nxt = (pend & ~limpa) | botao_ef;
   end

   assign bus.andar        = andar_q;
   assign bus.sobe         = (estado == SUBINDO);
   assign bus.desce        = (estado == DESCENDO);
   assign bus.porta_aberta = (estado == PORTA);
   assign bus.pendentes    = pend;
   assign bus.ocupado      = (estado != PARADO) || (|pend);
   assign bus.estado       = estado;

endmodule

// File: tb/tb_controle_direcao.sv
// Bench for controle_direcao: directed scenarios plus random requests, every
// cycle compared against an event-level elevator model.
module tb_controle_direcao;
  localparam int N  = 8;
  localparam int W  = 3;
  localparam int TV = 2;
  localparam int TP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controle_direcao_if #(.N_ANDARES(N), .W(W)) bus ();

  controle_direcao #(.N_ANDARES(N), .W(W), .T_VIAGEM(TV), .T_PORTA(TP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: mode 0 idle, 1 travelling, 2 door open
  int m_floor, m_mode, m_dir, m_tleft, m_dleft;
  bit m_req [N];

  // expected stop order for the directed scenarios
  logic [W-1:0] exp_q[$];
  bit sb_ativo = 1'b0;
  bit prev_porta = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tem_pedido(input int f, input int d);
    for (int k = f + d; k >= 0 && k < N; k += d)
      if (m_req[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_mode = 0; m_dir = 1; m_tleft = 0; m_dleft = 0;
    for (int i = 0; i < N; i++) m_req[i] = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] b);
    int clr;
    int old_floor;
    bit door;
    clr = -1;
    old_floor = m_floor;
    door = (m_mode == 2);
    case (m_mode)
      0: begin
        if (m_req[m_floor]) begin m_mode = 2; m_dleft = TP; clr = m_floor; end
        else if (tem_pedido(m_floor, 1)) begin m_mode = 1; m_dir = 1; m_tleft = TV; end
        else if (tem_pedido(m_floor, -1)) begin m_mode = 1; m_dir = -1; m_tleft = TV; end
      end
      1: begin
        m_tleft--;
        if (m_tleft == 0) begin
          m_floor += m_dir;
          if (m_req[m_floor]) begin m_mode = 2; m_dleft = TP; clr = m_floor; end
          else if (tem_pedido(m_floor, m_dir)) m_tleft = TV;
          else if (tem_pedido(m_floor, -m_dir)) begin m_dir = -m_dir; m_tleft = TV; end
          else m_mode = 0;
        end
      end
      default: begin
        if (b[m_floor]) m_dleft = TP;
        else begin
          m_dleft--;
          if (m_dleft == 0) begin
            if (tem_pedido(m_floor, m_dir)) begin m_mode = 1; m_tleft = TV; end
            else if (tem_pedido(m_floor, -m_dir)) begin m_mode = 1; m_dir = -m_dir; m_tleft = TV; end
            else m_mode = 0;
          end
        end
      end
    endcase
    for (int i = 0; i < N; i++)
      m_req[i] = (m_req[i] && i != clr) || (b[i] && !(door && i == old_floor));
  endtask

  task automatic verificar();
    logic [N-1:0] req_v;
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin req_v[i] = m_req[i]; any |= m_req[i]; end
    check("andar", 32'(bus.andar), 32'(m_floor));
    check("sobe", 32'(bus.sobe), 32'(m_mode == 1 && m_dir == 1));
    check("desce", 32'(bus.desce), 32'(m_mode == 1 && m_dir == -1));
    check("porta_aberta", 32'(bus.porta_aberta), 32'(m_mode == 2));
    check("pendentes", 32'(bus.pendentes), 32'(req_v));
    check("ocupado", 32'(bus.ocupado), 32'(m_mode != 0 || any));
    if (sb_ativo && bus.porta_aberta && !prev_porta) begin
      if (exp_q.size() == 0) check("stop_extra", 32'(bus.andar), 32'hFFFF);
      else check("stop_order", 32'(bus.andar), 32'(exp_q.pop_front()));
    end
    prev_porta = bus.porta_aberta;
  endtask

  task automatic ciclo(input logic [N-1:0] b);
    @(negedge clk);
    bus.botao = b;
    @(posedge clk);
    model_step(b);
    #1;
    verificar();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_andar"}, 32'(bus.andar), 32'd0);
    check({tag, "_sobe"}, 32'(bus.sobe), 32'd0);
    check({tag, "_desce"}, 32'(bus.desce), 32'd0);
    check({tag, "_porta"}, 32'(bus.porta_aberta), 32'd0);
    check({tag, "_pendentes"}, 32'(bus.pendentes), 32'd0);
    check({tag, "_ocupado"}, 32'(bus.ocupado), 32'd0);
  endtask

  task automatic reset_meio(input string tag);
    #2;
    bus.botao = '0;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    prev_porta = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int cnt;
  logic [N-1:0] b;
  int r;

  initial begin
    bus.botao = '0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // idle at 0, single pulse for floor 3
    sb_ativo = 1'b1;
    exp_q.push_back(3'd3);
    cnt = 0;
    ciclo(8'h08);
    for (int i = 0; i < 16; i++) begin
      ciclo(8'h00);
      if (bus.sobe) cnt++;
    end
    check("sobe_cycles", 32'(cnt), 32'd6);
    check("q_empty_1", 32'(exp_q.size()), 32'd0);

    // moving up from 3 toward 6, floors 1 and 5 pressed on the way
    exp_q.push_back(3'd5); exp_q.push_back(3'd6); exp_q.push_back(3'd1);
    ciclo(8'h40);
    ciclo(8'h00);
    ciclo(8'h22);
    for (int i = 0; i < 37; i++) ciclo(8'h00);
    check("q_empty_2", 32'(exp_q.size()), 32'd0);

    // go to floor 4, then door reopen
    exp_q.push_back(3'd4);
    ciclo(8'h10);
    for (int i = 0; i < 14; i++) ciclo(8'h00);
    exp_q.push_back(3'd4);
    ciclo(8'h10);
    ciclo(8'h00);
    check("door_latency", 32'(bus.porta_aberta), 32'd1);
    cnt = 1;
    ciclo(8'h00);
    if (bus.porta_aberta) cnt++;
    ciclo(8'h10);
    if (bus.porta_aberta) cnt++;
    check("reopen_pend4", 32'(bus.pendentes[4]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      ciclo(8'h00);
      if (bus.porta_aberta) cnt++;
    end
    check("door_total", 32'(cnt), 32'd6);
    check("q_empty_3", 32'(exp_q.size()), 32'd0);

    // idle at 4, floors 2 and 6 together: up first
    exp_q.push_back(3'd6); exp_q.push_back(3'd2);
    ciclo(8'h44);
    ciclo(8'h00);
    check("scan_up_first", 32'(bus.sobe), 32'd1);
    for (int i = 0; i < 28; i++) ciclo(8'h00);
    check("q_empty_4", 32'(exp_q.size()), 32'd0);

    // top floor stop then all the way down to 0
    exp_q.push_back(3'd7); exp_q.push_back(3'd0);
    cnt = 0;
    ciclo(8'h80);
    ciclo(8'h01);
    for (int i = 0; i < 42; i++) begin
      ciclo(8'h00);
      if (bus.sobe && bus.andar == 3'd7) cnt++;
      if (bus.desce && bus.andar == 3'd0) cnt++;
    end
    check("bound_violations", 32'(cnt), 32'd0);
    check("q_empty_5", 32'(exp_q.size()), 32'd0);
    sb_ativo = 1'b0;

    // asynchronous reset in the middle of travel
    ciclo(8'h40);
    for (int i = 0; i < 5; i++) ciclo(8'h00);
    check("pre_reset_andar", 32'(bus.andar), 32'd2);
    check("pre_reset_sobe", 32'(bus.sobe), 32'd1);
    check("pre_reset_pend", 32'(bus.pendentes), 32'h40);
    reset_meio("mid_reset");
    for (int i = 0; i < 4; i++) ciclo(8'h00);
    check("post_reset_ocupado", 32'(bus.ocupado), 32'd0);

    // random requests
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 15);
      b = '0;
      if (r == 0) b = N'($urandom);
      else if (r < 4) b[$urandom_range(0, N - 1)] = 1'b1;
      ciclo(b);
      if ($urandom_range(0, 299) == 0) reset_meio("rand_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
